modn_counter: RTL and testbench

Parametrised, loadable, cascaded mod-N up/down counter: the next generation of the team's single-digit mod-10 counter. It chains `DIGITS` mod-`MODULUS` digits with ripple-free, same-cycle carry/borrow. It adds count enable, load validation, terminal-count and wrap flags. With default parameters (`MODULUS`=10, `DIGITS`=1) it replaces the mod-10 counter at its existing bench interface (`rst`, `mode`, `load`, `data_in`, `data_out`), with `en` tied high.

---
 rtl/modn_pkg.sv | 22 ++
 rtl/modn_counter_if.sv | 24 ++
 rtl/modn_digit.sv | 36 +++
 rtl/modn_counter.sv | 89 ++++++++
 tb/tb_modn_counter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/modn_pkg.sv
// Shared types and helpers for the cascaded mod-N counter.
// Digit width sizing and the per-digit range check live here.
package modn_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    // Never narrower than one bit, even for an illegal modulus.
    function automatic int digit_w(input int m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic digit_ok(
        input logic [31:0] v,
        input int          m
    );
        return v < 32'(m);
    endfunction

endpackage

// File: rtl/modn_counter_if.sv
// Control and data bundle of the cascaded mod-N counter.
// The driver side uses master, the counter uses slave.
interface modn_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, mode, load, data_in,
        input  data_out, tc, wrap, load_err
    );

    modport slave (
        input  en, mode, load, data_in,
        output data_out, tc, wrap, load_err
    );
endinterface

// File: rtl/modn_digit.sv
// One mod-N digit register with load and up/down step.
// Terminal flags feed the cascade in the parent.
module modn_digit
    import modn_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int W       = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_in,
    input  count_dir_e   dir,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         is_max,
    output logic         is_zero
);
    localparam logic [W-1:0] TOP = W'(MODULUS - 1);

    assign is_max  = (q == TOP);
    assign is_zero = (q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= ld_val;
        end else if (step_in) begin
            unique case (dir)
                DIR_UP:   q <= is_max  ? '0  : q + 1'b1;
                DIR_DOWN: q <= is_zero ? TOP : q - 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/modn_counter.sv
// Loadable cascaded mod-N up/down counter with terminal,
// wrap and rejected-load flags.
module modn_counter
    import modn_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DIGITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    modn_counter_if.slave bus
);
    localparam int DIGIT_W = digit_w(MODULUS);
    localparam int W       = DIGITS * DIGIT_W;

    if (MODULUS < 2) begin : g_bad_mod
        $error("modn_counter: MODULUS must be >= 2");
    end
    if (DIGITS < 1) begin : g_bad_dig
        $error("modn_counter: DIGITS must be >= 1");
    end

    count_dir_e        dir;
    logic [DIGITS-1:0] is_max;
    logic [DIGITS-1:0] is_zero;
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] step;
    logic [W-1:0]      count;
    logic              all_term;
    logic              all_valid;
    logic              load_ok;
    logic              advance;

    assign dir = count_dir_e'(bus.mode);

    // Same-cycle carry: digit k steps when all lower digits are terminal.
    always_comb begin
        all_term = 1'b1;
        step     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            step[k]  = bus.en & ~bus.load & all_term;
            all_term = all_term & term[k];
        end
    end

    always_comb begin
        all_valid = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!digit_ok(32'(bus.data_in[k*DIGIT_W +: DIGIT_W]),
                          MODULUS))
                all_valid = 1'b0;
        end
    end

    assign load_ok = bus.load & all_valid;
    assign advance = bus.en & ~bus.load & all_term;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign term[k] = (dir == DIR_UP) ? is_max[k] : is_zero[k];

        modn_digit #(
            .MODULUS (MODULUS),
            .W       (DIGIT_W)
        ) u_digit (
            .clk     (clk),
            .rst     (rst),
            .step_in (step[k]),
            .dir     (dir),
            .load    (load_ok),
            .ld_val  (bus.data_in[k*DIGIT_W +: DIGIT_W]),
            .q       (count[k*DIGIT_W +: DIGIT_W]),
            .is_max  (is_max[k]),
            .is_zero (is_zero[k])
        );
    end

    assign bus.data_out = count;
    assign bus.tc       = all_term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wrap     <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            bus.wrap     <= advance;
            bus.load_err <= bus.load & ~all_valid;
        end
    end
endmodule

// File: tb/tb_modn_counter.sv
// Directed bench: 2-digit decade counter and 1-digit mod-6.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_modn_counter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    modn_counter_if #(.WIDTH(8)) bus_a ();
    modn_counter_if #(.WIDTH(3)) bus_b ();

    modn_counter #(.MODULUS(10), .DIGITS(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    modn_counter #(.MODULUS(6), .DIGITS(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        bus_a.load    = 1'b1;
        bus_a.data_in = v;
        tick();
        bus_a.load    = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus_a.en = 1'b0; bus_a.mode = 1'b1;
        bus_a.load = 1'b0; bus_a.data_in = '0;
        bus_b.en = 1'b0; bus_b.mode = 1'b1;
        bus_b.load = 1'b0; bus_b.data_in = '0;
        #3;
        check("rst_a_q", 32'(bus_a.data_out), 32'h00);
        check("rst_a_wrap", 32'(bus_a.wrap), 0);
        check("rst_a_lerr", 32'(bus_a.load_err), 0);
        check("rst_a_tc_up", 32'(bus_a.tc), 0);
        check("rst_b_q", 32'(bus_b.data_out), 0);
        #4 rst = 1'b1;
        tick();

        // reset mid-count
        load_a(8'h40);
        bus_a.en = 1'b1;
        repeat (7) tick();
        check("cnt47", 32'(bus_a.data_out), 32'h47);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_q", 32'(bus_a.data_out), 32'h00);
        check("mid_rst_wrap", 32'(bus_a.wrap), 0);
        check("mid_rst_lerr", 32'(bus_a.load_err), 0);
        check("mid_rst_tc_up", 32'(bus_a.tc), 0);
        bus_a.mode = 1'b0;
        #1;
        check("mid_rst_tc_dn", 32'(bus_a.tc), 1);
        bus_a.mode = 1'b1;
        rst = 1'b1;
        tick();
        check("post_rst_q", 32'(bus_a.data_out), 32'h01);

        // up wrap
        load_a(8'h98);
        check("ld98", 32'(bus_a.data_out), 32'h98);
        tick();
        check("up99", 32'(bus_a.data_out), 32'h99);
        check("up99_tc", 32'(bus_a.tc), 1);
        check("up99_wrap", 32'(bus_a.wrap), 0);
        tick();
        check("up00", 32'(bus_a.data_out), 32'h00);
        check("up00_wrap", 32'(bus_a.wrap), 1);
        tick();
        check("up01", 32'(bus_a.data_out), 32'h01);
        check("up01_wrap", 32'(bus_a.wrap), 0);

        // down wrap
        load_a(8'h01);
        check("ld01", 32'(bus_a.data_out), 32'h01);
        bus_a.mode = 1'b0;
        #1;
        check("dn01_tc", 32'(bus_a.tc), 0);
        tick();
        check("dn00", 32'(bus_a.data_out), 32'h00);
        check("dn00_tc", 32'(bus_a.tc), 1);
        tick();
        check("dn99", 32'(bus_a.data_out), 32'h99);
        check("dn99_wrap", 32'(bus_a.wrap), 1);
        tick();
        check("dn98", 32'(bus_a.data_out), 32'h98);
        check("dn98_wrap", 32'(bus_a.wrap), 0);

        // invalid loads, back to back, then valid
        bus_a.mode = 1'b1;
        load_a(8'h35);
        check("ld35", 32'(bus_a.data_out), 32'h35);
        bus_a.load = 1'b1;
        bus_a.data_in = 8'h3C;
        tick();
        check("bad3C_q", 32'(bus_a.data_out), 32'h35);
        check("bad3C_err", 32'(bus_a.load_err), 1);
        bus_a.data_in = 8'hA3;
        tick();
        check("badA3_q", 32'(bus_a.data_out), 32'h35);
        check("badA3_err", 32'(bus_a.load_err), 1);
        check("badA3_wrap", 32'(bus_a.wrap), 0);
        bus_a.data_in = 8'h25;
        tick();
        bus_a.load = 1'b0;
        check("ld25_q", 32'(bus_a.data_out), 32'h25);
        check("ld25_err", 32'(bus_a.load_err), 0);

        // hold with en low, then reverse direction
        load_a(8'h72);
        bus_a.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_q", 32'(bus_a.data_out), 32'h72);
            check("hold_wrap", 32'(bus_a.wrap), 0);
        end
        bus_a.mode = 1'b0;
        bus_a.en   = 1'b1;
        tick();
        check("dn71", 32'(bus_a.data_out), 32'h71);
        bus_a.en = 1'b0;

        // mod-6 single digit
        bus_b.load = 1'b1;
        bus_b.data_in = 3'd4;
        tick();
        bus_b.load = 1'b0;
        bus_b.en   = 1'b1;
        check("m6_4", 32'(bus_b.data_out), 4);
        check("m6_4_tc", 32'(bus_b.tc), 0);
        tick();
        check("m6_5", 32'(bus_b.data_out), 5);
        check("m6_5_tc", 32'(bus_b.tc), 1);
        tick();
        check("m6_0", 32'(bus_b.data_out), 0);
        check("m6_0_wrap", 32'(bus_b.wrap), 1);
        tick();
        check("m6_1", 32'(bus_b.data_out), 1);
        check("m6_1_wrap", 32'(bus_b.wrap), 0);
        bus_b.load = 1'b1;
        bus_b.data_in = 3'd7;
        tick();
        check("m6_bad7_q", 32'(bus_b.data_out), 1);
        check("m6_bad7_err", 32'(bus_b.load_err), 1);
        bus_b.data_in = 3'd6;
        tick();
        check("m6_bad6_q", 32'(bus_b.data_out), 1);
        check("m6_bad6_err", 32'(bus_b.load_err), 1);
        bus_b.data_in = 3'd5;
        tick();
        bus_b.load = 1'b0;
        check("m6_ld5_q", 32'(bus_b.data_out), 5);
        check("m6_ld5_err", 32'(bus_b.load_err), 0);
        bus_b.mode = 1'b0;
        tick();
        check("m6_dn4", 32'(bus_b.data_out), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
